hex_disp_sched: RTL and testbench
=================================

# hex_disp_sched

Schedules the board's six 7-segment displays between two independent value producers. The edge-detection datapath reports cycle counts and the debug/status path reports state words. A round-robin arbiter grants one producer at a time and latches its 24-bit value. A single shared `hex_7seg` decoder then converts the value one nibble per cycle into a shadow bank, and the whole bank is committed at once so the displays never tear. After each update the displays are held for a minimum time before another producer may take over.

## Interface
- `HOLD_CYCLES`, default 25_000_000: minimum cycles a committed value stays on the displays before re-arbitration (0.5 s at 50 MHz). 0 is legal and means no hold.
- `CNT_W`, default `$clog2(HOLD_CYCLES+1)`: width of the hold counter.

- `clk`  in  1  system clock; the single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-producer request; held high until the matching `ack`.
- `data0`  in  24  producer 0 value; six nibbles, nibble 0 goes to `hex0`.
- `data1`  in  24  producer 1 value.
- `blank_lz`  in  1  leading-zero blanking enable; sampled at grant.
- `ack`  out  2  one-cycle grant/latch strobe, one-hot.
- `hex0`..`hex5`  out  7 each, `[0:6]`  segment drive, active low, segment order 0..6.
- `busy`  out  1  high in any state other than IDLE.
- `cur_src`  out  1  index of the producer whose value is currently displayed.

## Operation
- States: IDLE, DECODE, HOLD.
- Reset state:
  - IDLE, round-robin pointer = 0.
  - `hex0`..`hex5` = 7'b1111111 (blank).
  - `ack` = 0, `busy` = 0, `cur_src` = 0.
  - Shadow bank blank; counters 0.
- IDLE:
  - If any `req` bit is high, grant it. With both high, grant the pointer's source.
  - Latch that source's data and `blank_lz`. Pulse the matching `ack` bit. Set the pointer to the other source. Go to DECODE with digit index 5.
- DECODE:
  - Each cycle, drive latched nibble[idx] into the shared decoder and write the result into shadow[idx]. Then decrement idx.
  - Digit order runs 5 down to 0, MSB first.
  - Leading-zero blanking: a `seen_nz` flag clears at grant. When `blank_lz` is latched and `seen_nz` is still 0, a zero nibble at idx != 0 writes 7'b1111111. Digit 0 always shows.
  - After idx 0 is written: commit the shadow bank to all six outputs on one edge, update `cur_src`, and load the hold counter.
- HOLD:
  - Count down from `HOLD_CYCLES`. Go to IDLE when the count expires.
  - With `HOLD_CYCLES` = 0, commit leads straight to IDLE.
  - Requests that arrive during DECODE or HOLD wait; they are neither acked nor dropped.
- A producer that drops `req` before `ack` is simply not served. No error flag.
- `busy` is high in DECODE and HOLD.

## Timing
- `req` is sampled at edge k. At that edge `ack` goes high and stays high for exactly one cycle; the data is latched at the same edge.
- Decode writes occur at edges k+1..k+6. Outputs change after edge k+7, which is also when HOLD begins.
- Latency from `req` sample to visible outputs: 7 cycles.
- Earliest next grant is at edge k+7+`HOLD_CYCLES` for `HOLD_CYCLES` > 0, or k+8 for `HOLD_CYCLES` = 0.
- The outputs and `cur_src` are registered and change only on commit edges or at reset.
- Reset asserted mid-DECODE or mid-HOLD: immediate, asynchronous. Outputs blank, state IDLE, pending decode discarded, no `ack`.
- Producer data may change after `ack` with no effect on the decode in progress.

## Structure
- Shared package `hex_disp_pkg` holds:
  - the state encoding (IDLE/DECODE/HOLD);
  - `N_DIGITS` = 6;
  - `SEG_BLANK` = 7'b1111111;
  - `N_SRC` = 2.
- Exactly one `hex_7seg` instance, fed from a mux on latched nibble[idx]. No per-digit decoders.
- The arbiter, FSM and hold counter stay inline; no further sub-modules.

## Test plan
- **Reset:** hold `reset_n` low with `req` = 2'b11 → all `hex` = 7'b1111111, `ack` = 0, `busy` = 0.
- **Single request:** `req` = 2'b01, `data0` = 24'h000001, `blank_lz` = 0, `HOLD_CYCLES` = 4.
  - `ack` = 2'b01 for one cycle.
  - 7 cycles later, `hex1`..`hex5` = 7'b0000001 and `hex0` = 7'b1001111.
  - `busy` falls after 4 further cycles.
- **Leading-zero blanking:** same value with `blank_lz` = 1 → `hex1`..`hex5` = 7'b1111111, `hex0` = 7'b1001111.
  - `data0` = 0 gives `hex0` = 7'b0000001 and the rest blank.
- **Round robin:** `req` = 2'b11 held continuously → `ack` sequence 01, 10, 01, …, and `cur_src` alternates 0, 1, 0 on commits.
  - Outputs never show a mix of sources at any cycle.
- **Hold enforcement:** `req[1]` rises one cycle after a `req[0]` commit with `HOLD_CYCLES` = 10 → `ack[1]` appears no earlier than 10 cycles after that commit.
- **Reset mid-DECODE:** pulse `reset_n` low at decode cycle 3 → outputs blank immediately, no commit, and the next request decodes cleanly.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the six-digit display scheduler: FSM encoding,
// display geometry and the nibble selector feeding the shared decoder.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int         N_DIGITS  = 6;
    localparam int         N_SRC     = 2;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [3:0] nibble_at(input logic [23:0] value, input logic [2:0] idx);
        logic [3:0] nib;
        nib = 4'h0;
        case (idx)
            3'd0:    nib = value[3:0];
            3'd1:    nib = value[7:4];
            3'd2:    nib = value[11:8];
            3'd3:    nib = value[15:12];
            3'd4:    nib = value[19:16];
            3'd5:    nib = value[23:20];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/hex_7seg.sv
// Hex nibble to active-low 7-segment pattern; bit 6 drives segment 0 (a)
// down to bit 0 driving segment 6 (g).
module hex_7seg
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'ha: seg = 7'b0001000;
            4'hb: seg = 7'b1100000;
            4'hc: seg = 7'b0110001;
            4'hd: seg = 7'b1000010;
            4'he: seg = 7'b0110000;
            4'hf: seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_disp_sched.sv
// Round-robin scheduler for six 7-segment displays: latches one producer's
// value, decodes it a nibble per cycle into a shadow bank, commits atomically.
module hex_disp_sched
    import hex_disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    input  logic        blank_lz,
    output logic [1:0]  ack,
    output logic [0:6]  hex0,
    output logic [0:6]  hex1,
    output logic [0:6]  hex2,
    output logic [0:6]  hex3,
    output logic [0:6]  hex4,
    output logic [0:6]  hex5,
    output logic        busy,
    output logic        cur_src
);

    localparam int         CW         = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [2:0] LAST_DIGIT = 3'(N_DIGITS - 1);
    // idx wraps past digit 0 to this value, marking the commit cycle
    localparam logic [2:0] IDX_COMMIT = 3'd7;

    state_t        state, state_nxt;
    logic          do_grant, do_commit, decoding, hold_done;
    logic          grant_src, rr_ptr, lat_src, lat_blank, seen_nz;
    logic [23:0]   lat_data;
    logic [2:0]    idx;
    logic [CW-1:0] hold_cnt;
    logic [3:0]    nib;
    logic [6:0]    dec_seg, wr_seg;
    logic [6:0]    shadow [N_DIGITS];
    logic [6:0]    disp   [N_DIGITS];

    assign grant_src = (req == 2'b11) ? rr_ptr : req[1];
    assign decoding  = (state == ST_DECODE) && (idx != IDX_COMMIT);
    assign hold_done = (hold_cnt <= CW'(1));

    assign nib = nibble_at(lat_data, idx);

    hex_7seg u_dec (
        .nibble (nib),
        .seg    (dec_seg)
    );

    assign wr_seg = (lat_blank && !seen_nz && (nib == 4'h0) && (idx != 3'd0)) ? SEG_BLANK : dec_seg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // An expiring hold arbitrates on the same edge so the next grant is not delayed a cycle
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_commit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    do_grant  = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (idx == IDX_COMMIT) begin
                    do_commit = 1'b1;
                    state_nxt = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_done) begin
                    if (req != 2'b00) begin
                        do_grant  = 1'b1;
                        state_nxt = ST_DECODE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack       <= 2'b00;
            rr_ptr    <= 1'b0;
            lat_data  <= '0;
            lat_blank <= 1'b0;
            lat_src   <= 1'b0;
            seen_nz   <= 1'b0;
            idx       <= IDX_COMMIT;
            hold_cnt  <= '0;
            cur_src   <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow[i] <= SEG_BLANK;
                disp[i]   <= SEG_BLANK;
            end
        end else begin
            ack <= 2'b00;
            if (do_grant) begin
                lat_data  <= grant_src ? data1 : data0;
                lat_blank <= blank_lz;
                lat_src   <= grant_src;
                ack       <= grant_src ? 2'b10 : 2'b01;
                rr_ptr    <= ~grant_src;
                idx       <= LAST_DIGIT;
                seen_nz   <= 1'b0;
            end else if (decoding) begin
                shadow[idx] <= wr_seg;
                if (nib != 4'h0) seen_nz <= 1'b1;
                idx <= idx - 3'd1;
            end
            if (do_commit) begin
                for (int i = 0; i < N_DIGITS; i++) disp[i] <= shadow[i];
                cur_src  <= lat_src;
                hold_cnt <= CW'(HOLD_CYCLES);
            end else if (state == ST_HOLD) begin
                hold_cnt <= hold_done ? '0 : hold_cnt - CW'(1);
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign hex0 = disp[0];
    assign hex1 = disp[1];
    assign hex2 = disp[2];
    assign hex3 = disp[3];
    assign hex4 = disp[4];
    assign hex5 = disp[5];

endmodule

// File: tb/tb_hex_disp_sched.sv
// Bench for hex_disp_sched: directed scenarios plus random producer traffic,
// checked by a grant/timing reference model and a display scoreboard.
module tb_hex_disp_sched;

    localparam int H = 4;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [23:0] data0 = '0;
    logic [23:0] data1 = '0;
    logic        blank_lz = 1'b0;
    logic [1:0]  ack;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        busy;
    logic        cur_src;

    int checks = 0;
    int errors = 0;

    logic [42:0] exp_q[$];

    hex_disp_sched #(.HOLD_CYCLES(H)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .data0    (data0),
        .data1    (data1),
        .blank_lz (blank_lz),
        .ack      (ack),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .busy     (busy),
        .cur_src  (cur_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int n);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[n];
    endfunction

    // Expected {hex5..hex0}: with blanking, zero digits above the most significant nonzero one go dark
    function automatic logic [41:0] model_disp(input logic [23:0] v, input logic bl);
        int msd;
        int n;
        logic [41:0] r;
        msd = -1;
        r = '0;
        for (int i = 0; i < 6; i++) if (((v >> (4 * i)) & 24'hf) != 0) msd = i;
        for (int i = 0; i < 6; i++) begin
            n = int'((v >> (4 * i)) & 24'hf);
            r[7*i +: 7] = (bl && i > msd && i != 0) ? BL : seg_of(n);
        end
        return r;
    endfunction

    // Reference model: grants, ack strobe, busy window
    int         cyc = 0;
    int         next_ok = 0;
    int         busy_until = 0;
    logic       ptr = 1'b0;
    logic [1:0] exp_ack = 2'b00;
    logic       exp_busy = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        logic src;
        if (!reset_n) begin
            cyc = 0; next_ok = 0; busy_until = 0; ptr = 1'b0;
            exp_ack = 2'b00; exp_busy = 1'b0;
        end else begin
            exp_ack = 2'b00;
            if (cyc >= next_ok && req != 2'b00) begin
                src = (req == 2'b11) ? ptr : req[1];
                exp_ack = src ? 2'b10 : 2'b01;
                ptr = ~src;
                exp_q.push_back({src, model_disp(src ? data1 : data0, blank_lz)});
                busy_until = cyc + 7 + H;
                next_ok = (H > 0) ? cyc + 7 + H : cyc + 8;
            end
            exp_busy = (cyc < busy_until);
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("ack", ack, exp_ack);
            chk("busy", busy, exp_busy);
        end
    end

    // Display monitor: an ack announces a commit seven cycles later
    int          cdown = 0;
    logic [42:0] cur_exp = {1'b0, {6{BL}}};

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cdown = 0;
            exp_q.delete();
            cur_exp = {1'b0, {6{BL}}};
        end else begin
            if (cdown > 0) begin
                cdown--;
                if (cdown == 0) begin
                    if (exp_q.size() == 0) chk("commit_expected", 1, 0);
                    else cur_exp = exp_q.pop_front();
                end
            end
            chk("display", {cur_src, hex5, hex4, hex3, hex2, hex1, hex0}, cur_exp);
            if (ack != 2'b00) cdown = 7;
        end
    end

    task automatic wait_ack(input int s, input int budget, output int waited);
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (ack[s]) return;
        end
        chk("ack_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_traffic(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            blank_lz = 1'($urandom_range(0, 1));
            for (int s = 0; s < 2; s++) begin
                if (req[s] && ack[s]) begin
                    req[s] = 1'b0;
                    if (s == 0) data0 = 24'($urandom); else data1 = 24'($urandom);
                end else if (req[s] && $urandom_range(0, 15) == 0) begin
                    req[s] = 1'b0;
                end else if (!req[s] && $urandom_range(0, 3) == 0) begin
                    req[s] = 1'b1;
                    if (s == 0) data0 = 24'($urandom) >> (4 * $urandom_range(0, 6));
                    else        data1 = 24'($urandom) >> (4 * $urandom_range(0, 6));
                end
            end
        end
    endtask

    initial begin
        int w;
        int gap;

        // Reset with both requests pending
        req = 2'b11;
        data0 = 24'h123456;
        data1 = 24'hfedcba;
        idle(3);
        chk("rst_hex0", hex0, BL);
        chk("rst_hex5", hex5, BL);
        chk("rst_ack", ack, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cur_src", cur_src, 1'b0);
        req = 2'b00;
        reset_n = 1'b1;
        idle(2);

        // Single request, no blanking
        data0 = 24'h000001; blank_lz = 1'b0; req = 2'b01;
        wait_ack(0, 20, w);
        req = 2'b00;
        data0 = 24'h999999;
        idle(7);
        chk("single_hex0", hex0, 7'b1001111);
        chk("single_hex1", hex1, 7'b0000001);
        chk("single_hex5", hex5, 7'b0000001);
        idle(3);
        chk("single_busy_hold", busy, 1'b1);
        idle(1);
        chk("single_busy_fall", busy, 1'b0);

        // Leading-zero blanking
        data0 = 24'h000001; blank_lz = 1'b1; req = 2'b01;
        wait_ack(0, 20, w);
        req = 2'b00;
        idle(7);
        chk("lz_hex0", hex0, 7'b1001111);
        chk("lz_hex1", hex1, BL);
        chk("lz_hex5", hex5, BL);
        idle(6);
        data0 = 24'h000000; blank_lz = 1'b1; req = 2'b01;
        wait_ack(0, 20, w);
        req = 2'b00;
        idle(7);
        chk("zero_hex0", hex0, 7'b0000001);
        chk("zero_hex3", hex3, BL);
        idle(6);

        // Round robin with both requests held
        req = 2'b11;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            data0 = 24'($urandom);
            data1 = 24'($urandom);
            blank_lz = 1'($urandom_range(0, 1));
        end
        req = 2'b00;
        idle(14);

        // Hold enforcement: source 1 asks one cycle after a source 0 commit
        data0 = 24'h00abcd; blank_lz = 1'b0; req = 2'b01;
        wait_ack(0, 20, w);
        req = 2'b00;
        idle(7);
        @(negedge clk);
        data1 = 24'h5a5a5a; req = 2'b10;
        wait_ack(1, 40, w);
        gap = 1 + w;
        req = 2'b00;
        chk("hold_gap", gap, H);
        idle(14);

        // Reset during the third decode cycle
        data1 = 24'h314159; req = 2'b10;
        wait_ack(1, 20, w);
        req = 2'b00;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_hex0", hex0, BL);
        chk("rstmid_hex4", hex4, BL);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_cur_src", cur_src, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        data0 = 24'h0badf0; blank_lz = 1'b1; req = 2'b01;
        wait_ack(0, 20, w);
        req = 2'b00;
        idle(7);
        chk("after_rst_hex5", hex5, BL);
        chk("after_rst_hex4", hex4, 7'b1100000);
        idle(6);

        // Random producers
        rand_traffic(500);
        req = 2'b00;
        idle(20);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
